// File: rtl/or3_pattern_seq_if.sv
// Signal bundle between the pattern sequencer and the 3-input OR stage it exercises.
// The master side is the sequencer; the slave side is the OR stage / supervising logic.
interface or3_pattern_seq_if;
    logic       start;
    logic       outA;
    logic       outB;
    logic       outC;
    logic       inD;
    logic       busy;
    logic       done;
    logic       mismatch;
    logic [3:0] err_cnt;
    logic [2:0] pattern_idx;

    modport master (
        input  start, inD,
        output outA, outB, outC, busy, done, mismatch, err_cnt, pattern_idx
    );

    modport slave (
        output start, inD,
        input  outA, outB, outC, busy, done, mismatch, err_cnt, pattern_idx
    );
endinterface

// File: rtl/or3_pattern_seq.sv
// Clocked stimulus sequencer and checker for a 3-input OR stage: walks all 8 input
// combinations for LOOPS passes, DWELL cycles each, and counts wrong OR results.
module or3_pattern_seq #(
    parameter int DWELL = 4,
    parameter int LOOPS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    or3_pattern_seq_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [3:0] LOOP_LAST  = 4'(LOOPS - 1);

    state_t     r_state;
    state_t     w_stateNext;
    logic [1:0] r_rstSync;
    logic       w_rstInt_n;
    logic [2:0] r_pattern;
    logic [2:0] w_patternNext;
    logic [7:0] r_dwell;
    logic [7:0] w_dwellNext;
    logic [3:0] r_loop;
    logic [3:0] w_loopNext;
    logic [3:0] r_errCnt;
    logic [3:0] w_errCntNext;
    logic       r_busy;
    logic       w_busyNext;
    logic       r_done;
    logic       w_doneNext;
    logic       r_mismatch;
    logic       w_mismatchNext;
    logic       w_sampleEdge;
    logic       w_expected;

    // Reset asserts everywhere at once but is released only on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstSync <= 2'b00;
        end else begin
            r_rstSync <= {r_rstSync[0], 1'b1};
        end
    end

    assign w_rstInt_n = r_rstSync[1];

    always_ff @(posedge clk or negedge w_rstInt_n) begin
        if (!w_rstInt_n) begin
            r_state    <= IDLE;
            r_pattern  <= 3'd0;
            r_dwell    <= 8'd0;
            r_loop     <= 4'd0;
            r_errCnt   <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_pattern  <= w_patternNext;
            r_dwell    <= w_dwellNext;
            r_loop     <= w_loopNext;
            r_errCnt   <= w_errCntNext;
            r_busy     <= w_busyNext;
            r_done     <= w_doneNext;
            r_mismatch <= w_mismatchNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_patternNext  = r_pattern;
        w_dwellNext    = r_dwell;
        w_loopNext     = r_loop;
        w_errCntNext   = r_errCnt;
        w_busyNext     = r_busy;
        w_doneNext     = 1'b0;
        w_mismatchNext = 1'b0;
        w_sampleEdge   = (r_dwell == DWELL_LAST);
        w_expected     = |r_pattern;

        unique case (r_state)
            IDLE: begin
                w_busyNext    = 1'b0;
                w_patternNext = 3'd0;
                if (bus.start) begin
                    w_stateNext  = RUN;
                    w_dwellNext  = 8'd0;
                    w_loopNext   = 4'd0;
                    w_errCntNext = 4'd0;
                    w_busyNext   = 1'b1;
                end
            end
            RUN: begin
                w_dwellNext = r_dwell + 8'd1;
                if (w_sampleEdge) begin
                    w_dwellNext   = 8'd0;
                    w_patternNext = r_pattern + 3'd1;
                    if (bus.inD != w_expected) begin
                        w_mismatchNext = 1'b1;
                        if (r_errCnt != 4'hF) begin
                            w_errCntNext = r_errCnt + 4'd1;
                        end
                    end
                    // Pattern 7 wraps to 0, which is also the idle drive value.
                    if (r_pattern == 3'd7) begin
                        w_loopNext = r_loop + 4'd1;
                        if (r_loop == LOOP_LAST) begin
                            w_stateNext = DONE;
                            w_loopNext  = 4'd0;
                            w_busyNext  = 1'b0;
                            w_doneNext  = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                w_stateNext = IDLE;
                w_busyNext  = 1'b0;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign bus.outA        = r_pattern[2];
    assign bus.outB        = r_pattern[1];
    assign bus.outC        = r_pattern[0];
    assign bus.pattern_idx = r_pattern;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.mismatch    = r_mismatch;
    assign bus.err_cnt     = r_errCnt;
endmodule
